// File: rtl/match_ctrl_pkg.sv
// Shared EX-stage definitions for the MATCH sequencer: state encoding,
// result sentinel, default geometry and the op's slot in the ALU control vector.
package match_ctrl_pkg;

  typedef logic [1:0] match_state_t;

  localparam match_state_t ST_IDLE = 2'd0;
  localparam match_state_t ST_SCAN = 2'd1;
  localparam match_state_t ST_DONE = 2'd2;

  localparam logic [31:0] NO_MATCH = 32'hFFFF_FFFF;

  localparam int WIN_W_DEF   = 8;
  localparam int MAX_POS_DEF = 24;

  localparam int ALU_CTRL_W    = 16;
  localparam int ALU_MATCH_BIT = 13;

endpackage

// File: rtl/match_ctrl_if.sv
// Pipeline <-> match sequencer handshake: operands and start/flush in,
// stall/busy/done and the matched offset out.
interface match_ctrl_if;

  logic        flush;
  logic        start;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        stallreq;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output flush, start, src1, src2,
    input  stallreq, busy, done, result
  );

  modport slave (
    input  flush, start, src1, src2,
    output stallreq, busy, done, result
  );

endinterface

// File: rtl/match_ctrl_cmp.sv
// Combinational window comparator: eq is high when every window bit
// equals the corresponding pattern bit.
module match_cmp #(
  parameter int WIN_W = 8
) (
  input  logic [WIN_W-1:0] window,
  input  logic [WIN_W-1:0] pat,
  output logic             eq
);

  logic [WIN_W-1:0] bit_eq;

  for (genvar gi = 0; gi < WIN_W; gi++) begin : g_bit
    assign bit_eq[gi] = ~(window[gi] ^ pat[gi]);
  end

  assign eq = &bit_eq;

endmodule

// File: rtl/match_ctrl.sv
// Multi-cycle MATCH sequencer: shifts the source word right one bit per
// cycle and reports the lowest offset where the low window equals the pattern.
module match_ctrl
  import match_ctrl_pkg::*;
#(
  parameter int WIN_W   = WIN_W_DEF,
  parameter int MAX_POS = MAX_POS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  match_ctrl_if.slave  bus
);

  localparam logic [4:0] POS_LAST = 5'(MAX_POS);

  match_state_t     state_q, state_d;
  logic [4:0]       pos_q, pos_d;
  logic [31:0]      sh_q, sh_d;
  logic [WIN_W-1:0] pat_q, pat_d;
  logic [31:0]      result_q, result_d;
  logic             win_eq;
  logic             accept;

  assign accept = (state_q == ST_IDLE) & bus.start & ~bus.flush;

  match_cmp #(.WIN_W(WIN_W)) u_cmp (
    .window (sh_q[WIN_W-1:0]),
    .pat    (pat_q),
    .eq     (win_eq)
  );

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    sh_d     = sh_q;
    pat_d    = pat_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          pat_d   = bus.src1[WIN_W-1:0];
          sh_d    = bus.src2;
          pos_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (win_eq) begin
          result_d = 32'(pos_q);
          state_d  = ST_DONE;
        end else if (pos_q == POS_LAST) begin
          result_d = NO_MATCH;
          state_d  = ST_DONE;
        end else begin
          sh_d  = {1'b0, sh_q[31:1]};
          pos_d = pos_q + 5'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A cancelled operation must leave the previously reported result intact.
    if (bus.flush) begin
      state_d  = ST_IDLE;
      pos_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pos_q    <= '0;
      sh_q     <= '0;
      pat_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      sh_q     <= sh_d;
      pat_q    <= pat_d;
      result_q <= result_d;
    end
  end

  // Stall covers the issuing cycle combinationally so the MATCH instruction holds in EX.
  assign bus.stallreq = ~rst & (accept | (state_q == ST_SCAN));
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE) & ~bus.flush;
  assign bus.result   = result_q;

endmodule

// File: doc/match_ctrl.md
# match_ctrl

Multi-cycle sequencer for the byte-pattern MATCH operation of the execute stage. It scans a 32-bit source word for the first occurrence of an 8-bit pattern, testing one bit offset per cycle. It raises a stall request to the pipeline while scanning and returns the matched bit offset to the ALU result path. It sits beside the ALU in EX: the ALU handles single-cycle ops, and this block handles `op_match`.

## Interface
Parameters:
- WIN_W, 8, pattern/window width in bits
- MAX_POS, 24, last bit offset tested (offsets 0..MAX_POS; requires MAX_POS+WIN_W ≤ 32)

Ports (clock and reset first):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  cancel in-flight operation (pipeline flush/exception)
- start  in  1  request a match; sampled only in IDLE
- src1  in  32  pattern source; bits [WIN_W-1:0] used
- src2  in  32  word to be searched
- stallreq  out  1  hold the pipeline while the operation is in flight
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse; result valid
- result  out  32  lowest matching offset, or NO_MATCH = 32'hFFFF_FFFF

## Operation
- States: IDLE, SCAN, DONE.
- IDLE, start=1, flush=0:
  - latch pat ← src1[WIN_W-1:0] and sh ← src2
  - pos ← 0
  - go to SCAN
- SCAN: compare sh[WIN_W-1:0] with pat.
  - Equal: result ← pos (zero-extended); go to DONE.
  - Not equal, pos == MAX_POS: result ← NO_MATCH; go to DONE.
  - Otherwise: sh ← {1'b0, sh[31:1]}, pos ← pos+1, stay in SCAN.
- DONE: done=1 for this cycle; go to IDLE unconditionally. A start seen in DONE is ignored.
- result holds its last value until the next completion. It is unaffected by flush.
- flush in any state: next state IDLE, pos ← 0, no done pulse. flush has priority over start in the same cycle.
- start outside IDLE is ignored. The operands are not re-sampled.
- stallreq = (state==IDLE & start & ~flush) | (state==SCAN). It is combinational so that the instruction issuing start is held in the same cycle.
- pos is 5 bits wide. It never wraps because SCAN exits at MAX_POS.
- Reset values: state IDLE; pos 0; sh 0; pat 0; result 32'h0; done 0; busy 0; stallreq 0.

## Timing
- Start accepted at edge T (start high in cycle T). SCAN tests offset k in cycle T+1+k.
- Match at offset k: DONE (done=1, result valid) in cycle T+2+k. Total latency k+2 cycles.
  - Best case, offset 0: done in T+2.
  - No match: 25 SCAN cycles; done in T+26.
- stallreq is high from cycle T through the last SCAN cycle. It is low in DONE, so the pipeline advances and captures result in that cycle.
- Back-to-back operations: the next start is accepted no earlier than the cycle after DONE.
- Asynchronous rst mid-SCAN: all outputs reach their reset values immediately, with no done pulse.

## Structure
- Shared package, next to the existing ALU defines:
  - state encoding (IDLE/SCAN/DONE, 2 bits)
  - NO_MATCH constant
  - WIN_W/MAX_POS defaults
  - the MATCH bit position in the alu_control vector
- One sub-module, match_cmp: a combinational WIN_W-bit window comparator (inputs window and pat, output eq). The FSM, shift register and counter stay in match_ctrl.

## Test plan
- Match at offset 0: src1=32'h0000_00A5, src2=32'h1234_56A5, start for one cycle. Expect stallreq high for 2 cycles, done in T+2, result=0.
- Interior match: src1=32'h3C, src2=32'h0003_C000 (0x3C at bit 12). Expect done in T+14, result=12.
- Last offset and no-match cases:
  - src1=32'hFF, src2=32'hFF00_0000. Expect result=24 in T+26.
  - src2=32'h0 with src1=32'h01. Expect result=32'hFFFF_FFFF in T+26.
- Flush and reset mid-operation:
  - flush asserted in the 5th SCAN cycle. Expect IDLE next cycle, no done, result unchanged, stallreq low.
  - Repeat with rst asserted instead. Expect immediate reset values.
- Handshake corner cases:
  - start held high through the whole operation. Expect a single accept, and a second accept only in the cycle after DONE.
  - start and flush in the same IDLE cycle. Expect no accept and stallreq=0.
